// File: rtl/vend_machine_multi_pkg.sv
// Shared types and helpers for the multi-item vending controller.
// Coin encoding, controller states, coin and price decoding.
package vend_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_20   = 2'b11;

  localparam int PV_W = 512;

  typedef enum logic [1:0] {
    IDLE,
    CREDIT,
    VEND,
    RETURN
  } state_t;

  function automatic logic [4:0] coin_value(
    input logic [1:0] c
  );
    logic [4:0] v;
    v = 5'd0;
    unique case (c)
      COIN_5:  v = 5'd5;
      COIN_10: v = 5'd10;
      COIN_20: v = 5'd20;
      default: v = 5'd0;
    endcase
    return v;
  endfunction

  // Bit-serial pick keeps the field width a run-time argument.
  function automatic logic [31:0] price_at(
    input logic [PV_W-1:0] vec,
    input int unsigned     idx,
    input int unsigned     cw
  );
    logic [31:0] r;
    logic [8:0]  bi;
    r = '0;
    for (int b = 0; b < 32; b++) begin
      bi = 9'(idx * cw + b);
      if (b < cw) r[b] = vec[bi];
    end
    return r;
  endfunction

endpackage

// File: rtl/vend_machine_multi_if.sv
// Front-end / driver bundle of the vending controller.
// master drives coins, keys and restock; slave is the controller.
interface vend_machine_multi_if #(
  parameter int NUM_ITEMS = 4,
  parameter int CREDIT_W  = 8,
  parameter int STOCK_W   = 4
);
  localparam int IW =
    (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;

  logic [1:0]           coin_in;
  logic                 select_valid;
  logic [IW-1:0]        select_item;
  logic                 cancel;
  logic                 restock_valid;
  logic [IW-1:0]        restock_item;
  logic [STOCK_W-1:0]   restock_qty;
  logic [NUM_ITEMS-1:0] dispense;
  logic                 refund;
  logic [CREDIT_W-1:0]  change_out;
  logic [CREDIT_W-1:0]  credit;
  logic                 coin_reject;
  logic                 select_err;
  logic [NUM_ITEMS-1:0] low_stock;
  logic [NUM_ITEMS-1:0] sold_out;

  modport master (
    output coin_in, select_valid, select_item,
    output cancel, restock_valid,
    output restock_item, restock_qty,
    input  dispense, refund, change_out, credit,
    input  coin_reject, select_err,
    input  low_stock, sold_out
  );

  modport slave (
    input  coin_in, select_valid, select_item,
    input  cancel, restock_valid,
    input  restock_item, restock_qty,
    output dispense, refund, change_out, credit,
    output coin_reject, select_err,
    output low_stock, sold_out
  );

endinterface

// File: rtl/vend_machine_multi_stock_bank.sv
// Per-item stock counters with vend/restock merge and saturation.
// Drives the low-stock and sold-out flags.
module vend_stock_bank #(
  parameter int NUM_ITEMS  = 4,
  parameter int IW         = 2,
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 5,
  parameter int LOW_THRESH = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dec_valid,
  input  logic [IW-1:0]        dec_item,
  input  logic                 restock_valid,
  input  logic [IW-1:0]        restock_item,
  input  logic [STOCK_W-1:0]   restock_qty,
  output logic [NUM_ITEMS-1:0] low_stock,
  output logic [NUM_ITEMS-1:0] sold_out
);

  localparam logic [STOCK_W:0] SMAX =
    {1'b0, {STOCK_W{1'b1}}};

  logic [STOCK_W-1:0] stock_q [NUM_ITEMS];
  logic [STOCK_W-1:0] stock_n [NUM_ITEMS];
  logic [STOCK_W:0]   sum;

  // One extra bit lets +qty-1 be resolved before clamping.
  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      sum = {1'b0, stock_q[i]};
      if (restock_valid && restock_item == IW'(i))
        sum = sum + {1'b0, restock_qty};
      if (dec_valid && dec_item == IW'(i))
        sum = sum - (STOCK_W+1)'(1);
      stock_n[i] = (sum > SMAX) ?
        SMAX[STOCK_W-1:0] : sum[STOCK_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ITEMS; i++)
        stock_q[i] <= STOCK_W'(INIT_STOCK);
    end else begin
      for (int i = 0; i < NUM_ITEMS; i++)
        stock_q[i] <= stock_n[i];
    end
  end

  for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_flag
    assign low_stock[i] =
      stock_q[i] <= STOCK_W'(LOW_THRESH);
    assign sold_out[i] = (stock_q[i] == '0);
  end

endmodule

// File: rtl/vend_machine_multi.sv
// Multi-item vending controller: credit, vend, change, refund.
// Define VEND_TIMEOUT_EN for the idle-credit auto-refund.
module vend_machine_multi
  import vend_pkg::*;
#(
  parameter int NUM_ITEMS = 4,
  parameter int CREDIT_W  = 8,
  parameter int STOCK_W   = 4,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICE_VEC =
    {8'd30, 8'd25, 8'd20, 8'd15},
  parameter int INIT_STOCK     = 5,
  parameter int LOW_THRESH     = 1,
  parameter int MAX_CREDIT     = 100,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input logic clk,
  input logic reset,
  vend_machine_multi_if.slave bus
);

  localparam int IW =
    (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;
  localparam logic [CREDIT_W:0] MAXC =
    (CREDIT_W+1)'(MAX_CREDIT);

  if (MAX_CREDIT + 20 >= (1 << CREDIT_W)
      || TIMEOUT_CYCLES < 1) begin : g_chk
    $error("vend_machine_multi: bad CREDIT_W/TIMEOUT");
  end

  state_t               state, state_n;
  logic [CREDIT_W-1:0]  credit_q, credit_n;
  logic [CREDIT_W-1:0]  change_q, change_n;
  logic [NUM_ITEMS-1:0] disp_q, disp_n;
  logic                 refund_q, refund_n;
  logic                 crej_q, crej_n;
  logic                 serr_q, serr_n;
  logic                 dec_v;
  logic [NUM_ITEMS-1:0] sold_out;
  logic [CREDIT_W-1:0]  price [NUM_ITEMS];

  for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_price
    assign price[i] = CREDIT_W'(
      price_at(PV_W'(PRICE_VEC), i, CREDIT_W));
  end

  logic                in_range, sel_ok, sel_take;
  logic                cancel_ok, coin_any, coin_ok;
  logic                reload, tmo;
  logic [IW-1:0]       sel_idx;
  logic [CREDIT_W-1:0] sel_price;
  logic [CREDIT_W:0]   coin_sum;

  assign in_range = {1'b0, bus.select_item}
                    < (IW+1)'(NUM_ITEMS);
  assign sel_idx   = in_range ? bus.select_item : '0;
  assign sel_price = price[sel_idx];
  assign sel_ok    = in_range && !sold_out[sel_idx]
                     && credit_q != '0
                     && credit_q >= sel_price
                     && state == CREDIT;
  assign cancel_ok = (state == CREDIT) && bus.cancel;
  assign sel_take  = !cancel_ok && bus.select_valid
                     && sel_ok;
  assign coin_sum  = {1'b0, credit_q}
                     + (CREDIT_W+1)'(coin_value(bus.coin_in));
  assign coin_any  = (bus.coin_in != COIN_NONE);
  // Cancel and select win the cycle; the coin is bounced.
  assign coin_ok   = coin_any && !cancel_ok && !sel_take
                     && (state == IDLE || state == CREDIT)
                     && coin_sum <= MAXC;
  assign reload    = coin_ok || bus.select_valid;

`ifdef VEND_TIMEOUT_EN
  logic [31:0] idle_cnt;

  assign tmo = (state == CREDIT) && !reload && !cancel_ok
               && idle_cnt == 32'(TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      idle_cnt <= '0;
    else if (state != CREDIT || state_n != CREDIT
             || reload)
      idle_cnt <= '0;
    else
      idle_cnt <= idle_cnt + 32'd1;
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_n  = state;
    credit_n = credit_q;
    change_n = '0;
    disp_n   = '0;
    refund_n = 1'b0;
    crej_n   = coin_any && !coin_ok;
    serr_n   = 1'b0;
    dec_v    = 1'b0;
    unique case (state)
      IDLE, CREDIT: begin
        if (cancel_ok || tmo) begin
          state_n  = RETURN;
          refund_n = 1'b1;
          change_n = credit_q;
          credit_n = '0;
        end else if (sel_take) begin
          state_n  = VEND;
          disp_n   = NUM_ITEMS'(1) << sel_idx;
          change_n = credit_q - sel_price;
          credit_n = '0;
          dec_v    = 1'b1;
        end else begin
          serr_n = bus.select_valid;
          if (coin_ok) begin
            credit_n = coin_sum[CREDIT_W-1:0];
            state_n  = CREDIT;
          end
        end
      end
      default: begin
        state_n = IDLE;
        serr_n  = bus.select_valid;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      credit_q <= '0;
      change_q <= '0;
      disp_q   <= '0;
      refund_q <= 1'b0;
      crej_q   <= 1'b0;
      serr_q   <= 1'b0;
    end else begin
      state    <= state_n;
      credit_q <= credit_n;
      change_q <= change_n;
      disp_q   <= disp_n;
      refund_q <= refund_n;
      crej_q   <= crej_n;
      serr_q   <= serr_n;
    end
  end

  vend_stock_bank #(
    .NUM_ITEMS  (NUM_ITEMS),
    .IW         (IW),
    .STOCK_W    (STOCK_W),
    .INIT_STOCK (INIT_STOCK),
    .LOW_THRESH (LOW_THRESH)
  ) u_stock (
    .clk           (clk),
    .reset         (reset),
    .dec_valid     (dec_v),
    .dec_item      (sel_idx),
    .restock_valid (bus.restock_valid),
    .restock_item  (bus.restock_item),
    .restock_qty   (bus.restock_qty),
    .low_stock     (bus.low_stock),
    .sold_out      (sold_out)
  );

  assign bus.sold_out    = sold_out;
  assign bus.dispense    = disp_q;
  assign bus.refund      = refund_q;
  assign bus.change_out  = change_q;
  assign bus.credit      = credit_q;
  assign bus.coin_reject = crej_q;
  assign bus.select_err  = serr_q;

endmodule

// File: tb/tb_vend_machine_multi.sv
// Bench for vend_machine_multi: directed plan plus random traffic
// against a credit/stock reference model.
module tb_vend_machine_multi;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vend_machine_multi_if #(
    .NUM_ITEMS(4), .CREDIT_W(8), .STOCK_W(4)
  ) bus ();

  vend_machine_multi dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  int price [4] = '{15, 20, 25, 30};
  int m_credit;
  bit m_busy;
  int m_stock [4];

  logic [3:0] e_disp;
  bit e_ref, e_crej, e_serr;
  int e_chg;

  function automatic int coin_val(input logic [1:0] c);
    return (c == 2'd1) ? 5 : (c == 2'd2) ? 10 :
           (c == 2'd3) ? 20 : 0;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_credit = 0;
    m_busy = 1'b0;
    for (int i = 0; i < 4; i++) m_stock[i] = 5;
    e_disp = '0; e_ref = 0; e_crej = 0; e_serr = 0;
    e_chg = 0;
  endtask

  // A vend or refund occupies the following cycle; only idle
  // cycles accept cancel, select and coins.
  task automatic model(input logic [1:0] c, input bit sv,
                       input int si, input bit cn,
                       input bit rv, input int ri,
                       input int rq);
    int v, dec;
    bit took;
    v = coin_val(c);
    dec = -1;
    took = 1'b0;
    e_disp = '0; e_ref = 0; e_crej = 0; e_serr = 0;
    e_chg = 0;
    if (m_busy) begin
      m_busy = 1'b0;
      e_crej = (v != 0);
      e_serr = sv;
    end else begin
      if (cn && m_credit > 0) begin
        e_ref = 1; e_chg = m_credit;
        m_credit = 0; took = 1;
      end else if (sv) begin
        if (m_stock[si] > 0 && m_credit > 0
            && m_credit >= price[si]) begin
          e_disp = 4'(1 << si);
          e_chg = m_credit - price[si];
          m_credit = 0; dec = si; took = 1;
        end else e_serr = 1;
      end
      if (v != 0) begin
        if (took || m_credit + v > 100) e_crej = 1;
        else m_credit += v;
      end
      m_busy = took;
    end
    if (dec >= 0) m_stock[dec]--;
    if (rv) m_stock[ri] =
      (m_stock[ri] + rq > 15) ? 15 : m_stock[ri] + rq;
  endtask

  task automatic check_all(input string p);
    logic [3:0] lo, so;
    for (int i = 0; i < 4; i++) begin
      lo[i] = (m_stock[i] <= 1);
      so[i] = (m_stock[i] == 0);
    end
    chk({p, ".credit"}, 32'(bus.credit), m_credit);
    chk({p, ".disp"}, 32'(bus.dispense), 32'(e_disp));
    chk({p, ".refund"}, 32'(bus.refund), 32'(e_ref));
    chk({p, ".change"}, 32'(bus.change_out), e_chg);
    chk({p, ".crej"}, 32'(bus.coin_reject), 32'(e_crej));
    chk({p, ".serr"}, 32'(bus.select_err), 32'(e_serr));
    chk({p, ".low"}, 32'(bus.low_stock), 32'(lo));
    chk({p, ".sold"}, 32'(bus.sold_out), 32'(so));
  endtask

  task automatic step(input string p, input logic [1:0] c,
                      input bit sv, input int si,
                      input bit cn, input bit rv,
                      input int ri, input int rq);
    bus.coin_in = c;
    bus.select_valid = sv;
    bus.select_item = 2'(si);
    bus.cancel = cn;
    bus.restock_valid = rv;
    bus.restock_item = 2'(ri);
    bus.restock_qty = 4'(rq);
    model(c, sv, si, cn, rv, ri, rq);
    @(posedge clk);
    #1;
    check_all(p);
    bus.coin_in = 2'b00;
    bus.select_valid = 1'b0;
    bus.cancel = 1'b0;
    bus.restock_valid = 1'b0;
  endtask

  task automatic coin(input string p, input logic [1:0] c);
    step(p, c, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic sel(input string p, input int si);
    step(p, 2'b00, 1, si, 0, 0, 0, 0);
  endtask

  task automatic idle(input string p);
    step(p, 2'b00, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.coin_in = 2'b00;
    bus.select_valid = 1'b0;
    bus.select_item = '0;
    bus.cancel = 1'b0;
    bus.restock_valid = 1'b0;
    bus.restock_item = '0;
    bus.restock_qty = '0;
    model_reset();
    #12;
    check_all("rst");
    @(negedge clk);
    reset = 1'b0;

    coin("a10", 2'd2);
    coin("a5", 2'd1);
    sel("a_sel0", 0);
    chk("tp1_disp", 32'(bus.dispense), 32'h1);
    chk("tp1_chg", 32'(bus.change_out), 0);
    idle("a_post");
    chk("tp1_pulse_end", 32'(bus.dispense), 0);

    coin("b20", 2'd3);
    coin("b10", 2'd2);
    sel("b_sel1", 1);
    chk("tp2_disp", 32'(bus.dispense), 32'h2);
    chk("tp2_chg", 32'(bus.change_out), 10);
    idle("b_post");

    coin("c5", 2'd1);
    coin("c10", 2'd2);
    step("c_cancel", 2'b00, 0, 0, 1, 0, 0, 0);
    chk("tp3_refund", 32'(bus.refund), 1);
    chk("tp3_chg", 32'(bus.change_out), 15);
    idle("c_post");

    for (int k = 1; k <= 5; k++) begin
      coin("d20", 2'd3);
      coin("d10", 2'd2);
      sel("d_sel3", 3);
      if (k == 4) chk("tp4_low3", 32'(bus.low_stock[3]), 1);
      if (k == 5) chk("tp4_sold3", 32'(bus.sold_out[3]), 1);
      idle("d_post");
    end
    coin("e20", 2'd3);
    coin("e10", 2'd2);
    sel("e_sel3", 3);
    chk("tp4_serr", 32'(bus.select_err), 1);
    chk("tp4_keep", 32'(bus.credit), 30);
    step("e_cancel", 2'b00, 0, 0, 1, 0, 0, 0);
    chk("tp4_ref30", 32'(bus.change_out), 30);
    idle("e_post");
    step("e_restock", 2'b00, 0, 0, 0, 1, 3, 3);
    chk("tp4_flags", 32'({bus.low_stock[3], bus.sold_out[3]}), 0);

    repeat (4) coin("f20", 2'd3);
    coin("f10", 2'd2);
    coin("f_over", 2'd3);
    chk("tp5_rej", 32'(bus.coin_reject), 1);
    chk("tp5_keep", 32'(bus.credit), 90);
    step("f_all", 2'd1, 1, 0, 1, 0, 0, 0);
    chk("tp5_ref", 32'(bus.change_out), 90);
    chk("tp5_nodisp", 32'(bus.dispense), 0);
    idle("f_post");

    coin("g20", 2'd3);
    coin("g5", 2'd1);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("g_rst");
    @(negedge clk);
    reset = 1'b0;

    for (int n = 0; n < 400; n++) begin
      logic [1:0] c;
      bit sv, cn, rv;
      c  = ($urandom_range(0, 1) == 1) ?
           2'($urandom_range(1, 3)) : 2'b00;
      sv = !m_busy && ($urandom_range(0, 3) == 0);
      cn = !m_busy && ($urandom_range(0, 11) == 0);
      rv = ($urandom_range(0, 9) == 0);
      step("rnd", c, sv, $urandom_range(0, 3), cn, rv,
           $urandom_range(0, 3), $urandom_range(0, 7));
    end

`ifdef VEND_TIMEOUT_EN
    if (m_busy) idle("t_pre");
    if (m_credit > 0) begin
      step("t_cancel", 2'b00, 0, 0, 1, 0, 0, 0);
      idle("t_post");
    end
    coin("t5", 2'd1);
    begin
      bit seen;
      int chg;
      seen = 1'b0;
      chg = 0;
      for (int w = 0; w < 1100 && !seen; w++) begin
        @(posedge clk);
        #1;
        if (bus.refund === 1'b1) begin
          seen = 1'b1;
          chg = int'(bus.change_out);
        end
      end
      chk("tmo_refund", 32'(seen), 1);
      chk("tmo_chg", chg, 5);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
